banked_memory: RTL and testbench

//  Parametrised byte-addressable unified memory for the MIPS core: one data port (MIPS

---
 rtl/banked_memory_pkg.sv | 58 +++++
 rtl/banked_memory_bank.sv | 41 ++++
 rtl/banked_memory.sv | 142 ++++++++++++++
 tb/tb_banked_memory.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/banked_memory_pkg.sv
// Shared access modes, FSM states and per-lane steering helpers for banked_memory.
package MemoryModesPackage;

  typedef enum logic [2:0] {
    NONE      = 3'd0,
    BYTE      = 3'd1,
    HALFWORD  = 3'd2,
    WORD      = 3'd3,
    WORDLEFT  = 3'd4,
    WORDRIGHT = 3'd5
  } ReadWriteModes;

  typedef enum logic {
    CLEAR = 1'b0,
    IDLE  = 1'b1
  } MemState;

  localparam logic [1:0] SEL_ZERO = 2'd0;
  localparam logic [1:0] SEL_LANE = 2'd1;
  localparam logic [1:0] SEL_EXT  = 2'd2;

  function automatic ReadWriteModes decode_mode(input logic [2:0] raw);
    return (raw > 3'd5) ? NONE : ReadWriteModes'(raw);
  endfunction

  // Lane g of a store at lane offset l: {write enable, source byte index into the store data}.
  function automatic logic [2:0] store_lane(input ReadWriteModes m, input logic [1:0] l,
                                            input logic [1:0] g);
    logic [2:0] r;
    r = 3'b000;
    case (m)
      BYTE:      r = {g == l, 2'd0};
      HALFWORD:  r = {g[1] == l[1], 1'b0, g[0]};
      WORD:      r = {1'b1, g};
      WORDLEFT:  r = {g <= l, g + 2'd3 - l};
      WORDRIGHT: r = {g >= l, g - l};
      default:   r = 3'b000;
    endcase
    return r;
  endfunction

  // Output byte k of a load at lane offset l: {source kind, source lane}.
  function automatic logic [3:0] load_lane(input ReadWriteModes m, input logic [1:0] l,
                                           input logic [1:0] k);
    logic [3:0] r;
    r = {SEL_ZERO, 2'd0};
    case (m)
      BYTE:      r = (k == 2'd0) ? {SEL_LANE, l} : {SEL_EXT, 2'd0};
      HALFWORD:  r = (k[1] == 1'b0) ? {SEL_LANE, l[1], k[0]} : {SEL_EXT, 2'd0};
      WORD:      r = {SEL_LANE, k};
      WORDLEFT:  r = (({1'b0, k} + {1'b0, l}) >= 3'd3) ? {SEL_LANE, k + l + 2'd1} : {SEL_ZERO, 2'd0};
      WORDRIGHT: r = (({1'b0, k} + {1'b0, l}) <= 3'd3) ? {SEL_LANE, k + l} : {SEL_ZERO, 2'd0};
      default:   r = {SEL_ZERO, 2'd0};
    endcase
    return r;
  endfunction

endpackage

// File: rtl/banked_memory_bank.sv
// One byte lane of banked_memory: DEPTH x 8 storage, one write port and two
// registered read-first read ports (data and instruction fetch).
module memory_bank #(
  parameter int AW = 14
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [7:0]    wdata,
  input  logic          rd_en,
  input  logic [AW-1:0] raddr,
  output logic [7:0]    rdata,
  input  logic          pc_en,
  input  logic [AW-1:0] pc_addr,
  output logic [7:0]    pc_data
);

  logic [7:0] mem [2**AW];
  logic [7:0] rdata_reg;
  logic [7:0] pc_data_reg;

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Read registers sample the pre-write contents on a same-edge write.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rdata_reg   <= 8'h00;
      pc_data_reg <= 8'h00;
    end else begin
      if (rd_en) rdata_reg <= mem[raddr];
      if (pc_en) pc_data_reg <= mem[pc_addr];
    end
  end

  assign rdata   = rdata_reg;
  assign pc_data = pc_data_reg;

endmodule

// File: rtl/banked_memory.sv
// Byte-addressable MIPS unified memory: data port with lwl/lwr-style steering plus fetch port.
// Define MEMORY_ALIGN_FAULT_EN to add the fault output and suppress misaligned accesses.
module banked_memory #(
  parameter int ADDR_WIDTH     = 16,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        reqValid,
  output logic        reqReady,
  input  logic [31:0] address,
  input  logic [31:0] data,
  input  logic [2:0]  writeMode,
  input  logic [2:0]  readMode,
  input  logic        unsignedLoad,
  output logic        dataValid,
  output logic [31:0] dataOutput,
  input  logic [31:0] pcAddress,
  output logic        pcValid,
  output logic [31:0] pcDataOutput
`ifdef MEMORY_ALIGN_FAULT_EN
  ,
  output logic        fault
`endif
);
  import MemoryModesPackage::*;

  localparam int AW = ADDR_WIDTH - 2;

  MemState         state_reg, state_next;
  logic [AW-1:0]   clear_cnt_reg;
  logic            ready_reg, valid_reg, pc_valid_reg, ld_unsigned_reg;
  ReadWriteModes   ld_mode_reg;
  logic [1:0]      ld_lane_reg;

  ReadWriteModes   wr_mode, rd_mode;
  logic            accept, misaligned, store_en, load_en, clearing, ext_bit;
  logic [1:0]      lane;
  logic [AW-1:0]   word_addr, pc_word_addr, bank_waddr;
  logic [3:0]      lane_we;
  logic [3:0][7:0] data_lanes, st_byte, rd_word, pc_word, ld_byte;
  logic            unused_bits;

  assign wr_mode      = decode_mode(writeMode);
  assign rd_mode      = decode_mode(readMode);
  assign lane         = address[1:0];
  assign word_addr    = address[ADDR_WIDTH-1:2];
  assign pc_word_addr = pcAddress[ADDR_WIDTH-1:2];
  assign data_lanes   = data;
  assign accept       = reqValid && reqReady;
  assign clearing     = (state_reg == CLEAR);
  assign bank_waddr   = clearing ? clear_cnt_reg : word_addr;
  assign unused_bits  = ^{address[31:ADDR_WIDTH], pcAddress[31:ADDR_WIDTH], pcAddress[1:0]};

`ifdef MEMORY_ALIGN_FAULT_EN
  logic fault_reg;
  assign misaligned = (((wr_mode == HALFWORD) || (rd_mode == HALFWORD)) && address[0]) ||
                      (((wr_mode == WORD) || (rd_mode == WORD)) && (address[1:0] != 2'b00));
  assign fault = fault_reg;
`else
  assign misaligned = 1'b0;
`endif

  assign store_en = accept && (wr_mode != NONE) && !misaligned;
  assign load_en  = accept && (rd_mode != NONE) && !misaligned;

  always_comb begin
    state_next = state_reg;
    if (state_reg == CLEAR && (&clear_cnt_reg)) state_next = IDLE;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg       <= (CLEAR_ON_RESET != 0) ? CLEAR : IDLE;
      clear_cnt_reg   <= '0;
      ready_reg       <= 1'b0;
      valid_reg       <= 1'b0;
      pc_valid_reg    <= 1'b0;
      ld_mode_reg     <= NONE;
      ld_lane_reg     <= 2'b00;
      ld_unsigned_reg <= 1'b0;
`ifdef MEMORY_ALIGN_FAULT_EN
      fault_reg       <= 1'b0;
`endif
    end else begin
      state_reg    <= state_next;
      ready_reg    <= (state_next == IDLE);
      valid_reg    <= load_en;
      pc_valid_reg <= (state_reg == IDLE);
      if (clearing) clear_cnt_reg <= clear_cnt_reg + 1'b1;
      if (load_en) begin
        ld_mode_reg     <= rd_mode;
        ld_lane_reg     <= lane;
        ld_unsigned_reg <= unsignedLoad;
      end
`ifdef MEMORY_ALIGN_FAULT_EN
      fault_reg <= accept && misaligned;
`endif
    end
  end

  // Sign source: top byte of the selected halfword, or the selected byte.
  assign ext_bit = !ld_unsigned_reg &&
                   ((ld_mode_reg == HALFWORD) ? rd_word[{ld_lane_reg[1], 1'b1}][7]
                                              : rd_word[ld_lane_reg][7]);

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      logic [2:0] st_sel;
      logic [3:0] ld_sel;

      assign st_sel      = store_lane(wr_mode, lane, 2'(gi));
      assign lane_we[gi] = clearing || (store_en && st_sel[2]);
      assign st_byte[gi] = clearing ? 8'h00 : data_lanes[st_sel[1:0]];
      assign ld_sel      = load_lane(ld_mode_reg, ld_lane_reg, 2'(gi));
      assign ld_byte[gi] = (ld_sel[3:2] == SEL_LANE) ? rd_word[ld_sel[1:0]] :
                           (ld_sel[3:2] == SEL_EXT)  ? {8{ext_bit}} : 8'h00;

      memory_bank #(.AW(AW)) u_bank (
        .clk     (clk),
        .rst     (rst),
        .we      (lane_we[gi]),
        .waddr   (bank_waddr),
        .wdata   (st_byte[gi]),
        .rd_en   (load_en),
        .raddr   (word_addr),
        .rdata   (rd_word[gi]),
        .pc_en   (state_reg == IDLE),
        .pc_addr (pc_word_addr),
        .pc_data (pc_word[gi])
      );
    end
  endgenerate

  assign reqReady     = ready_reg;
  assign dataValid    = valid_reg;
  assign dataOutput   = ld_byte;
  assign pcValid      = pc_valid_reg;
  assign pcDataOutput = pc_word;

endmodule

// File: tb/tb_banked_memory.sv
// Directed bench for banked_memory (ADDR_WIDTH=6): loads are scored by a queue-based monitor.
module tb_banked_memory;

  localparam logic [2:0] MN = 3'd0, MB = 3'd1, MH = 3'd2, MW = 3'd3, ML = 3'd4, MR = 3'd5;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        reqValid = 1'b0;
  logic        reqReady;
  logic [31:0] address = '0;
  logic [31:0] data = '0;
  logic [2:0]  writeMode = MN;
  logic [2:0]  readMode = MN;
  logic        unsignedLoad = 1'b0;
  logic        dataValid;
  logic [31:0] dataOutput;
  logic [31:0] pcAddress = '0;
  logic        pcValid;
  logic [31:0] pcDataOutput;
`ifdef MEMORY_ALIGN_FAULT_EN
  logic        fault;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] exp_q[$];
  string       name_q[$];

  always #5 clk = ~clk;

  banked_memory #(.ADDR_WIDTH(6), .CLEAR_ON_RESET(1)) dut (
    .clk          (clk),
    .rst          (rst),
    .reqValid     (reqValid),
    .reqReady     (reqReady),
    .address      (address),
    .data         (data),
    .writeMode    (writeMode),
    .readMode     (readMode),
    .unsignedLoad (unsignedLoad),
    .dataValid    (dataValid),
    .dataOutput   (dataOutput),
    .pcAddress    (pcAddress),
    .pcValid      (pcValid),
    .pcDataOutput (pcDataOutput)
`ifdef MEMORY_ALIGN_FAULT_EN
    ,
    .fault        (fault)
`endif
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end else begin
      $display("ok   %s: 0x%08h", name, act);
    end
  endtask

  // Monitor: every dataValid must match the oldest outstanding expected load.
  always @(negedge clk) begin
    if (rst && dataValid) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected dataValid: data 0x%08h, no load outstanding", dataOutput);
      end else begin
        check(name_q.pop_front(), dataOutput, exp_q.pop_front());
      end
    end
  end

  // Called at posedge+1; returns at the following posedge+1 after acceptance.
  task automatic do_req(input logic [31:0] a, input logic [31:0] d, input logic [2:0] wm,
                        input logic [2:0] rm, input logic u);
    reqValid = 1'b1; address = a; data = d; writeMode = wm; readMode = rm; unsignedLoad = u;
    @(posedge clk); #1;
    reqValid = 1'b0; writeMode = MN; readMode = MN;
  endtask

  task automatic load(input string name, input logic [31:0] a, input logic [2:0] rm,
                      input logic u, input logic [31:0] exp);
    exp_q.push_back(exp);
    name_q.push_back(name);
    do_req(a, 32'h0, MN, rm, u);
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d, input logic [2:0] wm);
    do_req(a, d, wm, MN, 1'b0);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Called at the negedge where rst was just released; counts not-ready cycles.
  task automatic count_clear(input string tag);
    int zeros;
    zeros = 0;
    while (!reqReady && zeros < 64) begin
      zeros++;
      @(negedge clk);
    end
    check({tag, " clear cycles"}, 32'(zeros), 32'd16);
    check({tag, " pcValid first idle cycle"}, {31'b0, pcValid}, 32'd0);
    @(negedge clk);
    check({tag, " pcValid after idle"}, {31'b0, pcValid}, 32'd1);
    check({tag, " reqReady idle"}, {31'b0, reqReady}, 32'd1);
    @(posedge clk); #1;
  endtask

  task automatic reset_outputs(input string tag);
    check({tag, " reqReady"}, {31'b0, reqReady}, 32'd0);
    check({tag, " dataValid"}, {31'b0, dataValid}, 32'd0);
    check({tag, " dataOutput"}, dataOutput, 32'd0);
    check({tag, " pcValid"}, {31'b0, pcValid}, 32'd0);
    check({tag, " pcDataOutput"}, pcDataOutput, 32'd0);
`ifdef MEMORY_ALIGN_FAULT_EN
    check({tag, " fault"}, {31'b0, fault}, 32'd0);
`endif
  endtask

  initial begin
    // Reset and full clear
    repeat (3) @(negedge clk);
    reset_outputs("reset");
    rst = 1'b1;
    count_clear("reset");

    load("cleared word @0x00", 32'h00, MW, 1'b0, 32'h0000_0000);
    load("cleared word @0x3C", 32'h3C, MW, 1'b0, 32'h0000_0000);

    // Byte / halfword extraction
    store(32'h10, 32'h1122_3344, MW);
    load("byte @0x13 signed", 32'h13, MB, 1'b0, 32'h0000_0011);
    load("half @0x12 signed", 32'h12, MH, 1'b0, 32'h0000_1122);
    load("byte @0x10 signed", 32'h10, MB, 1'b0, 32'h0000_0044);
    load("half @0x10 unsigned", 32'h10, MH, 1'b1, 32'h0000_3344);

    // Sign extension
    store(32'h20, 32'h80FF_7F01, MW);
    load("byte @0x22 signed", 32'h22, MB, 1'b0, 32'hFFFF_FFFF);
    load("byte @0x22 unsigned", 32'h22, MB, 1'b1, 32'h0000_00FF);
    load("half @0x22 signed", 32'h22, MH, 1'b0, 32'hFFFF_80FF);
    load("half @0x22 unsigned", 32'h22, MH, 1'b1, 32'h0000_80FF);
    load("half @0x20 signed", 32'h20, MH, 1'b0, 32'h0000_7F01);

    // dataOutput holds across a store-only request
    store(32'h24, 32'h0BAD_0BAD, MW);
    @(negedge clk);
    check("dataOutput held", dataOutput, 32'h0000_7F01);
    check("dataValid low after store", {31'b0, dataValid}, 32'd0);
    @(posedge clk); #1;

    // Unaligned left/right word accesses
    store(32'h30, 32'hAABB_CCDD, MW);
    load("wordleft @0x31", 32'h31, ML, 1'b0, 32'hCCDD_0000);
    load("wordright @0x31", 32'h31, MR, 1'b0, 32'h00AA_BBCC);
    store(32'h32, 32'h1122_3344, MR);
    load("word after wordright store", 32'h30, MW, 1'b0, 32'h3344_CCDD);
    store(32'h31, 32'h5566_7788, ML);
    load("word after wordleft store", 32'h30, MW, 1'b0, 32'h3344_5566);
    load("wordleft @0x30", 32'h30, ML, 1'b0, 32'h6600_0000);
    load("wordright @0x33", 32'h33, MR, 1'b0, 32'h0000_0033);
    load("wordleft @0x33", 32'h33, ML, 1'b0, 32'h3344_5566);

    // Modes 6/7 behave as NONE
    do_req(32'h10, 32'hFFFF_FFFF, 3'd6, 3'd7, 1'b0);
    load("word after mode 6 store", 32'h10, MW, 1'b0, 32'h1122_3344);

    // Read-first: same-request load+store, then pc fetch
    load("load+store @0x40 read-first", 32'h40, MW, 1'b0, 32'h0000_0000);
    address = 32'h40; data = 32'hDEAD_BEEF; writeMode = MW;
    // load() already ran the request; re-issue as combined load+store
    exp_q.push_back(32'h0000_0000);
    name_q.push_back("combined load+store @0x40");
    do_req(32'h40, 32'hDEAD_BEEF, MW, MW, 1'b0);
    pcAddress = 32'h40;
    @(posedge clk); @(negedge clk);
    check("pc @0x40 after store", pcDataOutput, 32'hDEAD_BEEF);
    @(posedge clk); #1;

    // pc fetch of a word being stored returns old data
    pcAddress = 32'h14;
    idle(1);
    store(32'h14, 32'h9999_AAAA, MW);
    @(negedge clk);
    check("pc same-edge store read-first", pcDataOutput, 32'h0000_0000);
    @(negedge clk);
    check("pc next cycle new data", pcDataOutput, 32'h9999_AAAA);
    @(posedge clk); #1;

    // Reset from IDLE, then reset again midway through CLEAR
    store(32'h3C, 32'hCAFE_F00D, MW);
    load("word @0x3C before reset", 32'h3C, MW, 1'b0, 32'hCAFE_F00D);
    idle(3);
    @(negedge clk);
    rst = 1'b0;
    #1;
    reset_outputs("idle reset");
    @(negedge clk);
    rst = 1'b1;
    repeat (8) @(negedge clk);
    check("mid-clear reqReady", {31'b0, reqReady}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    count_clear("reclear");
    load("word @0x10 after reclear", 32'h10, MW, 1'b0, 32'h0000_0000);
    load("word @0x3C after reclear", 32'h3C, MW, 1'b0, 32'h0000_0000);

    store(32'h40, 32'hCAFE_BABE, MW);
`ifdef MEMORY_ALIGN_FAULT_EN
    do_req(32'h41, 32'h1234_5678, MW, MW, 1'b0);
    @(negedge clk);
    check("misaligned word fault", {31'b0, fault}, 32'd1);
    check("misaligned word dataValid", {31'b0, dataValid}, 32'd0);
    @(negedge clk);
    check("fault one cycle", {31'b0, fault}, 32'd0);
    @(posedge clk); #1;
    store(32'h43, 32'h0000_1111, MH);
    @(negedge clk);
    check("misaligned half fault", {31'b0, fault}, 32'd1);
    @(posedge clk); #1;
    load("word after suppressed stores", 32'h40, MW, 1'b0, 32'hCAFE_BABE);
`else
    load("word @0x43 ignores low bits", 32'h43, MW, 1'b0, 32'hCAFE_BABE);
    load("half @0x43 signed", 32'h43, MH, 1'b0, 32'hFFFF_CAFE);
    load("half @0x41 unsigned", 32'h41, MH, 1'b1, 32'h0000_BABE);
`endif

    idle(4);
    check("scoreboard drained", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, checks %0d failures %0d", n_checks, n_fail);
    $fatal(1, "watchdog");
  end

endmodule
